// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, LCD command codes and default sizes for the LCD host sequencer.
package lcd_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, ISSUE, LOAD, DONE} state_t;
    localparam logic [3:0] CMD_LOAD    = 4'd0;
    localparam logic [3:0] CMD_REFRESH = 4'd1;
    localparam logic [3:0] CMD_SHIFT_R = 4'd2;
    localparam logic [3:0] CMD_SHIFT_L = 4'd3;
    localparam logic [3:0] CMD_SHIFT_U = 4'd4;
    localparam logic [3:0] CMD_SHIFT_D = 4'd5;
    localparam int DEF_IMG_BYTES = 108;
    localparam int DEF_CMD_DEPTH = 130;
endpackage

// File: rtl/lcd_out_counter.sv
// lcd_out_counter: 12-bit saturating count of controller result strobes; clear beats increment.
module lcd_out_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] count
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != 12'hFFF) count <= count + 1'b1;
endmodule

// File: rtl/lcd_host_seq.sv
// lcd_host_seq: fetches LCD commands and image bytes from ROMs and drives the LCD controller command port.
module lcd_host_seq
    import lcd_pkg::*;
#(
    parameter int CMD_DEPTH = DEF_CMD_DEPTH,
    parameter int IMG_BYTES = DEF_IMG_BYTES,
    parameter int CMD_AW    = 8,
    parameter int IMG_AW    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [CMD_AW-1:0] cmd_addr,
    input  logic [3:0]        cmd_rdata,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_rdata,
    input  logic              busy,
    input  logic              output_valid,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    output logic [7:0]        datain,
    output logic [11:0]       out_count,
    output logic              done
);
    localparam logic [CMD_AW-1:0] CMD_LAST = CMD_AW'(CMD_DEPTH - 1);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_BYTES - 1);
    state_t state;
    logic [CMD_AW-1:0] cmd_idx;
    logic [IMG_AW-1:0] k;
    logic clr, adv;
    assign clr    = start && (state == IDLE || state == DONE);
    assign adv    = (state == ISSUE && cmd != CMD_LOAD) || (state == LOAD && k == IMG_LAST);
    assign datain = state == LOAD ? img_rdata : 8'd0;
    lcd_out_counter u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .inc  (output_valid),
        .count(out_count)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_idx   <= '0;
            k         <= '0;
            cmd_addr  <= '0;
            img_addr  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= FETCH;
                    cmd_idx  <= '0;
                    cmd_addr <= '0;
                    done     <= 1'b0;
                end
                FETCH: state <= WAIT_RDY;
                WAIT_RDY: if (!busy) begin
                    cmd       <= cmd_rdata;
                    cmd_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (cmd == CMD_LOAD) begin
                    // img_addr already sits at 0 here, so byte 0 lands in the first LOAD cycle
                    state    <= LOAD;
                    k        <= '0;
                    img_addr <= IMG_AW'(IMG_BYTES > 1);
                end
                LOAD: begin
                    k        <= k + 1'b1;
                    img_addr <= img_addr == IMG_LAST ? img_addr : img_addr + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                k        <= '0;
                img_addr <= '0;
                if (cmd_idx == CMD_LAST) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state    <= FETCH;
                    cmd_idx  <= cmd_idx + 1'b1;
                    cmd_addr <= cmd_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_host_seq.sv
// tb_lcd_host_seq: ROM models, a busy/result controller model and a command scoreboard around lcd_host_seq.
module tb_lcd_host_seq;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] cmd_addr; logic [3:0] cmd_rdata; logic [6:0] img_addr; logic [7:0] img_rdata;
    logic busy, output_valid, cmd_valid, done; logic [3:0] cmd; logic [7:0] datain; logic [11:0] out_count;
    logic start1 = 1'b0, ov1 = 1'b0;
    logic [7:0] cmd_addr1; logic [6:0] img_addr1; logic [3:0] cmd1; logic cmd_valid1, done1;
    logic [7:0] datain1; logic [11:0] out_count1;
    logic man_busy = 1'b0, man_ov = 1'b0, model_en = 1'b0;
    logic [3:0] cmd_rom [256];
    logic [7:0] img_rom [128];
    logic [3:0] sb_q [$];
    int pend, n_chk = 0, n_fail = 0, cv_count = 0;
    typedef struct {logic st; logic ov; int cnt; logic dn; logic cv;} vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    lcd_host_seq dut (
        .clk(clk), .reset(reset), .start(start), .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
        .img_addr(img_addr), .img_rdata(img_rdata), .busy(busy), .output_valid(output_valid),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .out_count(out_count), .done(done)
    );
    lcd_host_seq #(.CMD_DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .cmd_addr(cmd_addr1), .cmd_rdata(4'd1),
        .img_addr(img_addr1), .img_rdata(8'd0), .busy(1'b0), .output_valid(ov1),
        .cmd(cmd1), .cmd_valid(cmd_valid1), .datain(datain1), .out_count(out_count1), .done(done1)
    );

    always_ff @(posedge clk) begin
        cmd_rdata <= cmd_rom[cmd_addr];
        img_rdata <= img_rom[img_addr];
    end

    // controller model: every command yields 16 result strobes, busy while they are pending
    always_ff @(posedge clk or negedge reset)
        if (!reset) pend <= 0;
        else if (cmd_valid) pend <= 16;
        else if (pend > 0) pend <= pend - 1;
    assign busy         = model_en ? (pend > 0) : man_busy;
    assign output_valid = model_en ? (pend > 0) : man_ov;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (reset && cmd_valid) begin
            cv_count++;
            if (sb_q.size() == 0) chk("cmd_sb_unexpected", 1, 0);
            else chk("cmd_sb", cmd, sb_q.pop_front());
        end

    initial begin
        logic seen_cv, seen_dn, seen_dat;
        int t;
        for (int i = 0; i < 256; i++) cmd_rom[i] = (i % 10 == 0) ? 4'd0 : 4'((i % 15) + 1);
        for (int i = 0; i < 128; i++) img_rom[i] = 8'(i + 16);
        tbl[0] = '{1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 2, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 0, 1'b0, 1'b0};
        #2 reset = 1'b0;
        repeat (2) tick();
        chk("rst_cmd_addr", cmd_addr, 0); chk("rst_img_addr", img_addr, 0); chk("rst_cmd", cmd, 0);
        chk("rst_cmd_valid", cmd_valid, 0); chk("rst_datain", datain, 0);
        chk("rst_out_count", out_count, 0); chk("rst_done", done, 0);
        reset = 1'b1;
        tick();
        // single-command instance: start/clear priority, ignored starts, strobe and done timing
        for (int i = 0; i < 8; i++) begin
            start1 = tbl[i].st; ov1 = tbl[i].ov;
            tick();
            chk($sformatf("tbl%0d_out_count", i), out_count1, tbl[i].cnt);
            chk($sformatf("tbl%0d_done", i), done1, tbl[i].dn);
            chk($sformatf("tbl%0d_cmd_valid", i), cmd_valid1, tbl[i].cv);
            if (tbl[i].cv) chk($sformatf("tbl%0d_cmd", i), cmd1, 1);
        end
        start1 = 1'b0; ov1 = 1'b0;
        chk("tbl_datain", datain1, 0); chk("tbl_img_addr", img_addr1, 0); chk("tbl_cmd_addr", cmd_addr1, 0);
        // load command: strobe in cycle 3, then 108 gapless bytes
        sb_q.push_back(cmd_rom[0]); sb_q.push_back(cmd_rom[1]);
        start = 1'b1; tick(); start = 1'b0;
        chk("fetch_cmd_addr", cmd_addr, 0);
        tick(); chk("cyc2_cmd_valid", cmd_valid, 0);
        tick(); chk("cyc3_cmd_valid", cmd_valid, 1); chk("cyc3_cmd", cmd, 0); chk("issue_img_addr", img_addr, 0);
        for (int k = 0; k < 108; k++) begin
            tick();
            chk($sformatf("load_byte%0d", k), datain, k + 16);
            chk($sformatf("load_cv%0d", k), cmd_valid, 0);
        end
        tick(); chk("post_load_datain", datain, 0); chk("post_load_cmd_addr", cmd_addr, 1);
        // busy stall for 20 cycles, with result strobes counted meanwhile
        man_busy = 1'b1; man_ov = 1'b1; seen_cv = 1'b0;
        repeat (20) begin tick(); seen_cv |= cmd_valid; end
        chk("stall_no_cmd_valid", seen_cv, 0); chk("stall_out_count", out_count, 20);
        man_busy = 1'b0; man_ov = 1'b0;
        tick(); chk("unstall_cmd_valid", cmd_valid, 1); chk("unstall_cmd", cmd, 2);
        man_busy = 1'b1;
        repeat (3) tick();
        chk("pre_rst_cmd_addr", cmd_addr, 2);
        // asynchronous abort mid-run
        reset = 1'b0; #1;
        chk("arst_cmd_addr", cmd_addr, 0); chk("arst_img_addr", img_addr, 0); chk("arst_cmd", cmd, 0);
        chk("arst_cmd_valid", cmd_valid, 0); chk("arst_datain", datain, 0);
        chk("arst_out_count", out_count, 0); chk("arst_done", done, 0);
        tick(); tick(); man_busy = 1'b0; reset = 1'b1;
        seen_cv = 1'b0; seen_dn = 1'b0; seen_dat = 1'b0;
        repeat (10) begin tick(); seen_cv |= cmd_valid; seen_dn |= done; seen_dat |= (datain != 0); end
        chk("idle_no_cmd_valid", seen_cv, 0); chk("idle_no_done", seen_dn, 0);
        chk("idle_no_datain", seen_dat, 0); chk("idle_cmd_addr", cmd_addr, 0);
        chk("sb_drained_a", sb_q.size(), 0);
        // full 130-command run against the controller model
        model_en = 1'b1;
        for (int i = 0; i < 130; i++) sb_q.push_back(cmd_rom[i]);
        cv_count = 0;
        start = 1'b1; tick(); start = 1'b0;
        t = 0;
        while (!done && t < 20000) begin tick(); t++; end
        chk("full_done_reached", done, 1);
        repeat (20) tick();
        chk("full_cmd_count", cv_count, 130); chk("sb_drained_b", sb_q.size(), 0);
        chk("full_out_count", out_count, 2080); chk("full_done_held", done, 1);
        // saturation, then restart from DONE with a simultaneous strobe
        model_en = 1'b0; man_busy = 1'b1; man_ov = 1'b1;
        repeat (4100) tick();
        chk("sat_out_count", out_count, 4095); chk("sat_cmd_addr", cmd_addr, 129);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_out_count", out_count, 0); chk("restart_cmd_addr", cmd_addr, 0); chk("restart_done", done, 0);
        tick(); chk("restart_count_resumes", out_count, 1);
        man_ov = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
